// File: rtl/dram_responder.sv
// dram_responder: memory-side responder for the shared DRAM port.
// Serves byte/half/word loads and stores against an on-chip byte-laned
// word RAM with a fixed access latency, and clears the RAM after reset.
//
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   w_dram_addr     byte address of the request
//   w_dram_wdata    right-aligned store data
//   w_dram_le       load request pulse
//   w_dram_we_t     store request pulse (wins over w_dram_le)
//   w_dram_ctrl     [1:0] size (0 byte, 1 half, 2/3 word), [2] load unsigned
//   w_dram_odata    extended load result, held until the next completed load
//   w_dram_busy     high while clearing or serving; requests taken only when low
//   w_init_done     high once the post-reset RAM clear has finished
//   w_misalign_err  (only with DRAM_RESP_MISALIGN_ERR_EN) one-cycle pulse on a
//                   misaligned access, which is then suppressed
//
// Optional feature macro: DRAM_RESP_MISALIGN_ERR_EN
module dram_responder #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned LATENCY    = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] w_dram_addr,
  input  logic [31:0] w_dram_wdata,
  input  logic        w_dram_le,
  input  logic        w_dram_we_t,
  input  logic [2:0]  w_dram_ctrl,
  output logic [31:0] w_dram_odata,
  output logic        w_dram_busy,
  output logic        w_init_done
`ifdef DRAM_RESP_MISALIGN_ERR_EN
  ,
  output logic        w_misalign_err
`endif
);

  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
  localparam int unsigned LAT_W  = 8;
  localparam int unsigned BADR_W = ADDR_WIDTH + 2;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WAIT, ST_DONE} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic [LAT_W-1:0]        wait_cnt_q, wait_cnt_d;
  logic                    busy_q, busy_d;
  logic                    init_done_q, init_done_d;
  logic [31:0]             odata_q, odata_d;
  logic [BADR_W-1:0]       addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [2:0]              ctrl_q, ctrl_d;
  logic                    store_q, store_d;
`ifdef DRAM_RESP_MISALIGN_ERR_EN
  logic                    err_q, err_d;
`endif

  logic [31:0]             mem_q [DEPTH];

  logic                    mem_we_c;
  logic [ADDR_WIDTH-1:0]   mem_idx_c;
  logic [3:0]              mem_be_c;
  logic [31:0]             mem_wdata_c;

  logic [ADDR_WIDTH-1:0]   acc_idx_c;
  logic [1:0]              lane_c;
  logic [31:0]             rd_word_c;
  logic [7:0]              rd_byte_c;
  logic [15:0]             rd_half_c;
  logic [3:0]              acc_be_c;
  logic [31:0]             acc_wd_c;
  logic [31:0]             load_c;
  logic                    misalign_c;

  // Upper address bits fold onto the RAM (wrap), so they are never looked at.
  logic                    unused_addr_c;
  assign unused_addr_c = ^w_dram_addr[31:BADR_W];

  // Lane decode, replicated store data and extended load data for the latched request.
  always_comb begin
    acc_idx_c  = addr_q[BADR_W-1:2];
    lane_c     = addr_q[1:0];
    rd_word_c  = mem_q[acc_idx_c];
    rd_byte_c  = rd_word_c[{lane_c, 3'b000} +: 8];
    rd_half_c  = addr_q[1] ? rd_word_c[31:16] : rd_word_c[15:0];
    acc_be_c   = 4'hf;
    acc_wd_c   = wdata_q;
    load_c     = rd_word_c;
    misalign_c = 1'b0;
    case (ctrl_q[1:0])
      2'd0: begin
        acc_be_c = 4'b0001 << lane_c;
        acc_wd_c = {4{wdata_q[7:0]}};
        load_c   = ctrl_q[2] ? {24'd0, rd_byte_c} : {{24{rd_byte_c[7]}}, rd_byte_c};
      end
      2'd1: begin
        acc_be_c   = addr_q[1] ? 4'b1100 : 4'b0011;
        acc_wd_c   = {2{wdata_q[15:0]}};
        load_c     = ctrl_q[2] ? {16'd0, rd_half_c} : {{16{rd_half_c[15]}}, rd_half_c};
        misalign_c = addr_q[0];
      end
      default: begin
        misalign_c = |addr_q[1:0];
      end
    endcase
  end

  // Next-state, request capture and RAM write port.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    busy_d      = busy_q;
    init_done_d = init_done_q;
    odata_d     = odata_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ctrl_d      = ctrl_q;
    store_d     = store_q;
`ifdef DRAM_RESP_MISALIGN_ERR_EN
    err_d       = 1'b0;
`endif
    mem_we_c    = 1'b0;
    mem_idx_c   = acc_idx_c;
    mem_be_c    = acc_be_c;
    mem_wdata_c = acc_wd_c;

    case (state_q)
      ST_INIT: begin
        mem_we_c    = 1'b1;
        mem_idx_c   = clr_cnt_q;
        mem_be_c    = 4'hf;
        mem_wdata_c = 32'd0;
        clr_cnt_d   = clr_cnt_q + ADDR_WIDTH'(1);
        if (&clr_cnt_q) begin
          state_d     = ST_IDLE;
          busy_d      = 1'b0;
          init_done_d = 1'b1;
        end
      end
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (w_dram_le || w_dram_we_t) begin
          addr_d     = w_dram_addr[BADR_W-1:0];
          wdata_d    = w_dram_wdata;
          ctrl_d     = w_dram_ctrl;
          store_d    = w_dram_we_t;
          busy_d     = 1'b1;
          wait_cnt_d = LAT_W'(1);
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q + LAT_W'(1);
        if (wait_cnt_q == LAT_W'(LATENCY)) begin
          state_d    = ST_DONE;
          busy_d     = 1'b0;
          wait_cnt_d = '0;
`ifdef DRAM_RESP_MISALIGN_ERR_EN
          err_d = misalign_c;
          if (store_q) mem_we_c = !misalign_c;
          else         odata_d  = misalign_c ? 32'd0 : load_c;
`else
          if (store_q) mem_we_c = 1'b1;
          else         odata_d  = load_c;
`endif
        end
      end
      default: state_d = ST_INIT;
    endcase

    // A reset landing on the access edge must not commit the write.
    if (RST) mem_we_c = 1'b0;
  end

  // Control and request registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_INIT;
      clr_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      busy_q      <= 1'b1;
      init_done_q <= 1'b0;
      odata_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ctrl_q      <= '0;
      store_q     <= 1'b0;
`ifdef DRAM_RESP_MISALIGN_ERR_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
      odata_q     <= odata_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ctrl_q      <= ctrl_d;
      store_q     <= store_d;
`ifdef DRAM_RESP_MISALIGN_ERR_EN
      err_q       <= err_d;
`endif
    end
  end

  // Byte-laned RAM write port.
  always_ff @(posedge CLK) begin
    if (mem_we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be_c[b]) mem_q[mem_idx_c][8*b +: 8] <= mem_wdata_c[8*b +: 8];
      end
    end
  end

  assign w_dram_odata = odata_q;
  assign w_dram_busy  = busy_q;
  assign w_init_done  = init_done_q;
`ifdef DRAM_RESP_MISALIGN_ERR_EN
  assign w_misalign_err = err_q;
`endif

endmodule
